// File: rtl/jelly3_instruction_fetch_pc.sv
// Multi-thread program-counter generator for the jfive fetch path.
// Holds one PC per hardware thread and issues threads round-robin, one slot per accepted cycle.
module jelly3_instruction_fetch_pc #(
    parameter int  ID_BITS     = 2,
    parameter type id_t        = logic [ID_BITS-1:0],
    parameter int  PC_BITS     = 32,
    parameter type pc_t        = logic [PC_BITS-1:0],
    parameter int  INSTR_BYTES = 4,
    parameter pc_t RESET_PC    = '0,
    parameter pc_t MEM_BASE    = '0,
    parameter pc_t MEM_SIZE    = pc_t'('h1_0000)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cke,
    input  logic [2**ID_BITS-1:0]   thread_enable,
    input  logic                    branch_en,
    input  logic [ID_BITS-1:0]      branch_id,
    input  logic [PC_BITS-1:0]      branch_pc,
    output logic [ID_BITS-1:0]      m_id,
    output logic [PC_BITS-1:0]      m_pc,
    output logic                    m_mem,
    output logic                    m_valid,
    input  logic                    m_ready
);

    localparam int THREADS = 2**ID_BITS;

    logic [THREADS-1:0][PC_BITS-1:0] pc_tab;

    id_t  rr_q,      rr_d;
    id_t  m_id_q,    m_id_d;
    pc_t  m_pc_q,    m_pc_d;
    logic m_mem_q,   m_mem_d;
    logic m_valid_q, m_valid_d;

    logic advance;
    logic branch;
    pc_t  sel_pc;
    pc_t  sel_offset;
    logic sel_en;

    always_comb begin
        advance    = cke && (m_ready || !m_valid_q);
        branch     = cke && branch_en;
        sel_pc     = pc_t'(pc_tab[rr_q]);
        sel_en     = thread_enable[rr_q];
        sel_offset = sel_pc - MEM_BASE;

        rr_d      = rr_q;
        m_id_d    = m_id_q;
        m_pc_d    = m_pc_q;
        m_mem_d   = m_mem_q;
        m_valid_d = m_valid_q;

        if (advance) begin
            m_id_d    = rr_q;
            m_pc_d    = sel_pc;
            m_mem_d   = (sel_offset < MEM_SIZE);
            // A redirect of the thread being issued kills that slot; its new PC goes out next round.
            m_valid_d = sel_en && !(branch && (id_t'(branch_id) == rr_q));
            rr_d      = rr_q + id_t'(1);
        end else if (branch && m_valid_q && (m_id_q == id_t'(branch_id))) begin
            // A held fetch for a redirected thread is stale; drop it but keep the data stable.
            m_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_q      <= '0;
            m_id_q    <= '0;
            m_pc_q    <= '0;
            m_mem_q   <= 1'b0;
            m_valid_q <= 1'b0;
        end else begin
            rr_q      <= rr_d;
            m_id_q    <= m_id_d;
            m_pc_q    <= m_pc_d;
            m_mem_q   <= m_mem_d;
            m_valid_q <= m_valid_d;
        end
    end

    for (genvar gi = 0; gi < THREADS; gi++) begin : g_thread
        pc_t pc_q;
        pc_t pc_d;

        // Branch redirect wins over the sequential increment in the same cycle.
        always_comb begin
            pc_d = pc_q;
            if (branch && (id_t'(branch_id) == id_t'(gi))) begin
                pc_d = pc_t'(branch_pc);
            end else if (advance && (rr_q == id_t'(gi)) && thread_enable[gi]) begin
                pc_d = pc_q + pc_t'(INSTR_BYTES);
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                pc_q <= RESET_PC;
            end else begin
                pc_q <= pc_d;
            end
        end

        assign pc_tab[gi] = PC_BITS'(pc_q);
    end

    assign m_id    = m_id_q;
    assign m_pc    = m_pc_q;
    assign m_mem   = m_mem_q;
    assign m_valid = m_valid_q;

endmodule

// File: tb/tb_jelly3_instruction_fetch_pc.sv
// Scoreboard bench for jelly3_instruction_fetch_pc: directed stimulus pushes hand-computed
// expected transfers, a negedge monitor pops them on every accepted output.
module tb_jelly3_instruction_fetch_pc;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cke = 1'b1;
    logic [3:0]  thread_enable = 4'b1111;
    logic        branch_en = 1'b0;
    logic [1:0]  branch_id = 2'd0;
    logic [31:0] branch_pc = 32'h0;
    logic [1:0]  m_id;
    logic [31:0] m_pc;
    logic        m_mem;
    logic        m_valid;
    logic        m_ready = 1'b1;

    always #5 clk = ~clk;

    jelly3_instruction_fetch_pc #(
        .ID_BITS     (2),
        .PC_BITS     (32),
        .INSTR_BYTES (4),
        .RESET_PC    (32'h0),
        .MEM_BASE    (32'h0),
        .MEM_SIZE    (32'h100)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cke           (cke),
        .thread_enable (thread_enable),
        .branch_en     (branch_en),
        .branch_id     (branch_id),
        .branch_pc     (branch_pc),
        .m_id          (m_id),
        .m_pc          (m_pc),
        .m_mem         (m_mem),
        .m_valid       (m_valid),
        .m_ready       (m_ready)
    );

    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] pc;
        logic        mem;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic push(input logic [1:0] id, input logic [31:0] pc, input logic mem);
        exp_q.push_back({id, pc, mem});
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic cycles(input int n);
        repeat (n) cycle();
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end else begin
            $display("check %s: %0h ok", name, act);
        end
    endtask

    // A transfer happens at the next rising edge when the block is clocked, out of reset,
    // and the output is valid and accepted.
    always @(negedge clk) begin
        if (!reset && cke && m_valid && m_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL xfer_unexpected: got id %0d pc %h mem %0d, required none",
                         m_id, m_pc, m_mem);
            end else begin
                mon_e = exp_q.pop_front();
                if (m_id !== mon_e.id || m_pc !== mon_e.pc || m_mem !== mon_e.mem) begin
                    n_fail++;
                    $display("FAIL xfer: got id %0d pc %h mem %0d, required id %0d pc %h mem %0d",
                             m_id, m_pc, m_mem, mon_e.id, mon_e.pc, mon_e.mem);
                end else begin
                    $display("xfer id %0d pc %h mem %0d ok", m_id, m_pc, m_mem);
                end
            end
        end
    end

    initial begin
        cycles(3);
        check("reset_valid", 32'(m_valid), 32'd0);
        check("reset_mem",   32'(m_mem),   32'd0);

        // Plain round-robin after reset, all threads enabled.
        for (int k = 0; k < 8; k++) begin
            push(2'(k % 4), (k < 4) ? 32'h0 : 32'h4, 1'b1);
        end
        reset = 1'b0;
        cycle();
        check("first_valid", 32'(m_valid), 32'd1);
        check("first_id",    32'(m_id),    32'd0);
        check("first_pc",    m_pc,         32'h0);
        cycles(7);

        // Threads 1 and 3 disabled for two rounds, then re-enabled.
        push(2'd0, 32'h8,  1'b1);
        push(2'd2, 32'h8,  1'b1);
        push(2'd0, 32'hC,  1'b1);
        push(2'd2, 32'hC,  1'b1);
        push(2'd0, 32'h10, 1'b1);
        push(2'd1, 32'h8,  1'b1);
        push(2'd2, 32'h10, 1'b1);
        push(2'd3, 32'h8,  1'b1);
        thread_enable = 4'b0101;
        cycle();
        cycle();
        check("bubble_valid", 32'(m_valid), 32'd0);
        cycles(6);
        thread_enable = 4'b1111;
        cycles(4);

        // Stall with id 2 presented, then flush it with a branch.
        push(2'd0, 32'h14, 1'b1);
        push(2'd1, 32'hC,  1'b1);
        cycles(3);
        m_ready = 1'b0;
        repeat (5) begin
            cycle();
            check("hold_valid", 32'(m_valid), 32'd1);
            check("hold_id",    32'(m_id),    32'd2);
            check("hold_pc",    m_pc,         32'h14);
            check("hold_mem",   32'(m_mem),   32'd1);
        end
        branch_en = 1'b1;
        branch_id = 2'd2;
        branch_pc = 32'h100;
        cycle();
        branch_en = 1'b0;
        check("flush_valid", 32'(m_valid), 32'd0);
        check("flush_id",    32'(m_id),    32'd2);
        check("flush_pc",    m_pc,         32'h14);
        push(2'd3, 32'hC,   1'b1);
        push(2'd0, 32'h18,  1'b1);
        push(2'd1, 32'h10,  1'b1);
        push(2'd2, 32'h100, 1'b0);
        push(2'd3, 32'h10,  1'b1);
        push(2'd0, 32'h1C,  1'b1);
        push(2'd1, 32'h14,  1'b1);
        push(2'd2, 32'h104, 1'b0);
        push(2'd3, 32'h14,  1'b1);
        m_ready = 1'b1;
        cycles(9);

        // Branch on thread 1 in the very cycle its slot is issued.
        push(2'd0, 32'h20,  1'b1);
        push(2'd2, 32'h108, 1'b0);
        push(2'd3, 32'h18,  1'b1);
        push(2'd0, 32'h24,  1'b1);
        push(2'd1, 32'h40,  1'b1);
        push(2'd2, 32'h10C, 1'b0);
        push(2'd3, 32'h1C,  1'b1);
        cycle();
        branch_en = 1'b1;
        branch_id = 2'd1;
        branch_pc = 32'h40;
        cycle();
        branch_en = 1'b0;
        check("kill_valid", 32'(m_valid), 32'd0);
        check("kill_id",    32'(m_id),    32'd1);
        cycles(6);

        // Window edge at 0x100 and wrap from the top of the address space.
        push(2'd0, 32'h28,        1'b1);
        push(2'd1, 32'h44,        1'b1);
        push(2'd2, 32'h110,       1'b0);
        push(2'd3, 32'hFC,        1'b1);
        push(2'd0, 32'h2C,        1'b1);
        push(2'd1, 32'h48,        1'b1);
        push(2'd2, 32'h114,       1'b0);
        push(2'd3, 32'h100,       1'b0);
        push(2'd0, 32'h30,        1'b1);
        push(2'd1, 32'h4C,        1'b1);
        push(2'd2, 32'h118,       1'b0);
        push(2'd3, 32'hFFFF_FFFC, 1'b0);
        push(2'd0, 32'h34,        1'b1);
        push(2'd1, 32'h50,        1'b1);
        push(2'd2, 32'h11C,       1'b0);
        push(2'd3, 32'h0,         1'b1);
        branch_en = 1'b1;
        branch_id = 2'd3;
        branch_pc = 32'hFC;
        cycle();
        branch_en = 1'b0;
        cycles(7);
        branch_en = 1'b1;
        branch_pc = 32'hFFFF_FFFC;
        cycle();
        branch_en = 1'b0;
        cycles(7);

        // Clock enable low freezes everything, including a pending branch.
        push(2'd0, 32'h38, 1'b1);
        push(2'd1, 32'h54, 1'b1);
        cke       = 1'b0;
        branch_en = 1'b1;
        branch_id = 2'd0;
        branch_pc = 32'h80;
        repeat (3) begin
            cycle();
            check("cke_hold_valid", 32'(m_valid), 32'd1);
            check("cke_hold_id",    32'(m_id),    32'd3);
            check("cke_hold_pc",    m_pc,         32'h0);
        end
        cke       = 1'b1;
        branch_en = 1'b0;
        cycles(3);

        // Reset mid-stream overrides a simultaneous branch; sequence restarts at id 0.
        reset     = 1'b1;
        branch_en = 1'b1;
        branch_id = 2'd2;
        branch_pc = 32'h200;
        cycle();
        check("midreset_valid", 32'(m_valid), 32'd0);
        check("midreset_mem",   32'(m_mem),   32'd0);
        push(2'd0, 32'h0, 1'b1);
        push(2'd1, 32'h0, 1'b1);
        push(2'd2, 32'h0, 1'b1);
        push(2'd3, 32'h0, 1'b1);
        push(2'd0, 32'h4, 1'b1);
        reset     = 1'b0;
        branch_en = 1'b0;
        cycles(6);
        m_ready = 1'b0;
        cycle();
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
